uart_mmio: RTL and testbench
============================

# uart_mmio

Memory-mapped I/O controller between the Riscv151 memory stage and the on-chip `uart`. It decodes CPU loads and stores in the 0x8000_00xx window and provides a UART status register, a buffered RX data register and a TX data register. It also provides cycle and retired-instruction counters that software reads for benchmarking. The echo program polls this block, and the off-chip UART test path runs through it.

## Interface
Parameters:
- `RX_FIFO_DEPTH`, default 8: RX byte buffer depth; must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  CPU clock.
- `rst`  in  1  Synchronous, active-high reset.
- `addr`  in  32  Byte address of the current load or store; only bits [7:0] are decoded when [31:8]==24'h800000.
- `wdata`  in  32  Store data; only [7:0] is used for TX.
- `we`  in  1  Store strobe, one cycle per store.
- `re`  in  1  Load strobe, one cycle per load.
- `instr_commit`  in  1  Pulses once per retired instruction.
- `rdata`  out  32  Registered load data.
- `uart_tx_data`  out  8  Byte to the UART transmitter.
- `uart_tx_valid`  out  1  TX handshake valid.
- `uart_tx_ready`  in  1  TX handshake ready.
- `uart_rx_data`  in  8  Byte from the UART receiver.
- `uart_rx_valid`  in  1  RX handshake valid.
- `uart_rx_ready`  out  1  RX handshake ready.

## Operation
Memory map (offsets from 0x8000_0000):
- 0x00, read: status register `{30'b0, rx_nonempty, tx_free}`. `tx_free` = !`uart_tx_valid`.
- 0x04, read: returns `{24'b0, fifo_head}` and pops one byte. If the FIFO is empty, returns 0 and does not pop.
- 0x08, write: if `tx_free`, latch `wdata[7:0]` and raise `uart_tx_valid`. If not `tx_free`, the write is dropped silently.
- 0x10, read: cycle counter.
- 0x14, read: instruction counter.
- 0x18, write: clears both counters.

Address handling:
- Any other address in the window, and any address outside it, reads 0. Writes to those addresses are ignored.
- `re` and `we` are never both high in the same cycle. If they are, `we` wins and `rdata` is 0.

RX path:
- A byte is pushed into the FIFO when `uart_rx_valid && uart_rx_ready`.
- `uart_rx_ready` = !`rst` && !full.

TX path:
- `uart_tx_valid` stays high until the cycle in which `uart_tx_ready` is also high, then clears on that edge.
- `uart_tx_data` is stable while `uart_tx_valid` is high.

Counters:
- The cycle counter increments every cycle that is not in reset.
- The instruction counter increments on `instr_commit`.
- Both counters are 32-bit and wrap from 0xFFFF_FFFF to 0.
- A clear via 0x18 overrides any increment in the same cycle.

## Timing
- Reset values: `rdata`=0, `uart_tx_valid`=0, `uart_tx_data`=0, `uart_rx_ready`=0, FIFO empty, both counters 0.
- Load latency is 1 cycle: `rdata` is valid on the edge after `re`. `rdata` holds its value until the next `re`.
- Store effects are visible in the following cycle. A status read 1 cycle after a TX write returns `tx_free`=0.
- Full FIFO with a pop in the same cycle: the pop succeeds. No push occurs that cycle, because ready was low. Ready returns to 1 on the next cycle.
- Empty FIFO with a push and a 0x04 read in the same cycle: the read returns 0 and the pushed byte is retained. `rx_nonempty`=1 on the next cycle.
- A TX write in the same cycle as the handshake completion of the previous byte is dropped, because `tx_free` was 0 at the write.
- A counter read in the same cycle as a clear returns the pre-clear value.
- `rst` asserted mid-operation clears everything on that edge. A pending TX byte is abandoned and buffered RX bytes are lost.
- FIFO pointers are log2(`RX_FIFO_DEPTH`)+1 bits wide, using the extra bit for full/empty wrap detection.

## Structure
- Shared package `riscv_mmio_pkg`:
  - Address constants: `MMIO_BASE`, `UART_CTRL`=0x00, `UART_RX`=0x04, `UART_TX`=0x08, `CYC_CNT`=0x10, `INST_CNT`=0x14, `CNT_RST`=0x18.
  - Status bit indices.
- Sub-module `sync_fifo`, parameterised width and depth, holds the RX buffer. Its ports are push/pop/full/empty/head, with pop on empty and push on full ignored.
- The address decode, TX holding register, counters and `rdata` register live in `uart_mmio`.

## Test plan
- Reset, then read 0x00 -> `rdata`=0x1. Read 0x10 after 5 idle cycles -> 5 ±1 per the 1-cycle latency; the exact value is 6 when counted from the first non-reset cycle.
- Push 0x7A on the RX handshake, read 0x00 -> 0x3. Read 0x04 -> 0x7A. Read 0x00 -> 0x1.
- Write 0x41 to 0x08 with `uart_tx_ready`=0 for 10 cycles -> `uart_tx_valid`=1 and `uart_tx_data`=0x41 held throughout. A second write of 0x42 is dropped. Raise ready -> valid clears next edge and `tx_free` returns.
- Push 9 bytes 0x01..0x09 with `RX_FIFO_DEPTH`=8 -> `uart_rx_ready` drops after the 8th. Eight 0x04 reads return 0x01..0x08. A ninth read returns 0.
- Pulse `instr_commit` 3 times, write 0x18 in the same cycle as a 4th pulse -> the next read of 0x14 returns 0. Preload the cycle counter to 0xFFFF_FFFF via force -> it wraps to 0.
- Assert `rst` while `uart_tx_valid`=1 and the FIFO holds 3 bytes -> next cycle valid=0, status=0x1, a 0x04 read returns 0.

Source files
------------

// File: rtl/riscv_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mmio_pkg
// Description : Shared address map and status bit layout for the Riscv151
//               memory-mapped UART / counter block.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_mmio_pkg;

  // Upper 24 address bits that select the MMIO window
  localparam logic [23:0] MMIO_BASE = 24'h800000;

  // Register offsets inside the window
  localparam logic [7:0] UART_CTRL = 8'h00;
  localparam logic [7:0] UART_RX   = 8'h04;
  localparam logic [7:0] UART_TX   = 8'h08;
  localparam logic [7:0] CYC_CNT   = 8'h10;
  localparam logic [7:0] INST_CNT  = 8'h14;
  localparam logic [7:0] CNT_RST   = 8'h18;

  // Status register bit positions
  localparam int STAT_TX_FREE     = 0;
  localparam int STAT_RX_NONEMPTY = 1;

  // True when the address falls inside the MMIO window
  function automatic logic in_mmio_window(input logic [31:0] a);
    return (a[31:8] == MMIO_BASE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered pointers. Push on full and
//               pop on empty are ignored. Pointers carry one extra wrap bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bit means the buffer is full
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next-state pointer arithmetic
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule
`default_nettype wire

// File: rtl/uart_mmio.sv
`default_nettype none
// ============================================================================
// Module      : uart_mmio
// Description : MMIO decode for the Riscv151 memory stage: UART status,
//               buffered RX, TX holding register, cycle and instruction
//               counters, and a registered load-data port.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mmio
  import riscv_mmio_pkg::*;
#(
  parameter int RX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic        instr_commit,
  output logic [31:0] rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic [31:0] cyc_cnt_q, cyc_cnt_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;

  logic        in_win;
  logic [7:0]  off;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_head;
  logic        rx_pop;
  logic        tx_wr;
  logic        cnt_clr;
  logic [31:0] status;
  logic [31:0] rd_val;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign in_win  = in_mmio_window(addr);
  assign off     = addr[7:0];

  // A store always takes priority over a simultaneous load
  assign rx_pop  = re && !we && in_win && (off == UART_RX);
  assign tx_wr   = we && in_win && (off == UART_TX) && !tx_valid_q;
  assign cnt_clr = we && in_win && (off == CNT_RST);

  assign uart_rx_ready = !rst && !fifo_full;
  assign uart_tx_valid = tx_valid_q;
  assign uart_tx_data  = tx_data_q;
  assign rdata         = rdata_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (uart_rx_valid && uart_rx_ready),
    .din_i   (uart_rx_data),
    .pop_i   (rx_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // Status word assembled from the live TX/RX state
  always_comb begin
    status                   = '0;
    status[STAT_TX_FREE]     = !tx_valid_q;
    status[STAT_RX_NONEMPTY] = !fifo_empty;
  end

  // Load data mux; unmapped and out-of-window addresses read zero
  always_comb begin
    rd_val = '0;
    if (in_win) begin
      case (off)
        UART_CTRL: rd_val = status;
        UART_RX:   rd_val = fifo_empty ? 32'd0 : {24'd0, fifo_head};
        CYC_CNT:   rd_val = cyc_cnt_q;
        INST_CNT:  rd_val = inst_cnt_q;
        default:   rd_val = '0;
      endcase
    end
  end

  // Next-state for load data, TX holding register and counters
  always_comb begin
    rdata_d    = rdata_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    cyc_cnt_d  = cyc_cnt_q + 32'd1;
    inst_cnt_d = inst_cnt_q + {31'd0, instr_commit};

    if (re) rdata_d = we ? 32'd0 : rd_val;

    // Write only lands when idle, so a write during handshake completion drops
    if (tx_wr) begin
      tx_valid_d = 1'b1;
      tx_data_d  = wdata[7:0];
    end else if (tx_valid_q && uart_tx_ready) begin
      tx_valid_d = 1'b0;
    end

    if (cnt_clr) begin
      cyc_cnt_d  = '0;
      inst_cnt_d = '0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      cyc_cnt_q  <= '0;
      inst_cnt_q <= '0;
    end else begin
      rdata_q    <= rdata_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      cyc_cnt_q  <= cyc_cnt_d;
      inst_cnt_q <= inst_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_mmio
// Description : Scoreboard bench for uart_mmio with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mmio;

  localparam int K_RDATA = 0;
  localparam int K_TXV   = 1;
  localparam int K_TXD   = 2;
  localparam int K_RXR   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic        instr_commit = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_valid = 1'b0;
  logic        uart_rx_ready;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc_tb = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] mon_act;

  uart_mmio #(.RX_FIFO_DEPTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .wdata         (wdata),
    .we            (we),
    .re            (re),
    .instr_commit  (instr_commit),
    .rdata         (rdata),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_tb <= cyc_tb + 1;

  function automatic logic [31:0] pick(input int kind);
    case (kind)
      K_RDATA: return rdata;
      K_TXV:   return {31'd0, uart_tx_valid};
      K_TXD:   return {24'd0, uart_tx_data};
      default: return {31'd0, uart_rx_ready};
    endcase
  endfunction

  // Monitor: retire every expectation whose cycle has arrived
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc_tb) begin
        mon_act = pick(sb[i].kind);
        n_cmp++;
        if (mon_act !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", sb[i].name, mon_act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expectation on current DUT state, checked before the next edge
  task automatic expect_sig(input int kind, input logic [31:0] e, input string nm);
    sb.push_back('{nm, kind, e, cyc_tb});
  endtask

  // Load: result appears after the next edge
  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    re   = 1'b1;
    addr = a;
    sb.push_back('{nm, K_RDATA, e, cyc_tb + 1});
    tick();
    re = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    n_cmp++;
    if (uart_rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL inline_rst_rxready: got %b expected 0", uart_rx_ready);
    end
    expect_sig(K_RDATA, 32'h0, "rst_rdata");
    expect_sig(K_TXV,   32'h0, "rst_txv");
    expect_sig(K_TXD,   32'h0, "rst_txd");
    expect_sig(K_RXR,   32'h0, "rst_rxready");
    tick();
    rst = 1'b0;
    expect_sig(K_RXR, 32'h1, "rxready_after_rst");
    rd(32'h8000_0000, 32'h1, "status_idle");
    repeat (5) tick();
    rd(32'h8000_0010, 32'd6, "cyc_cnt_6");

    // Single RX byte
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h7A;
    tick();
    uart_rx_valid = 1'b0;
    rd(32'h8000_0000, 32'h3, "status_rx");
    rd(32'h8000_0004, 32'h7A, "rx_7a");
    rd(32'h8000_0000, 32'h1, "status_rx_drained");

    // TX held while ready low; second write dropped
    wr(32'h8000_0008, 32'hFFFF_FF41);
    for (int i = 0; i < 10; i++) begin
      expect_sig(K_TXV, 32'h1, "tx_hold_valid");
      expect_sig(K_TXD, 32'h41, "tx_hold_data");
      tick();
    end
    rd(32'h8000_0000, 32'h0, "status_tx_busy");
    wr(32'h8000_0008, 32'h42);
    expect_sig(K_TXD, 32'h41, "tx_drop_busy");
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
    expect_sig(K_TXV, 32'h0, "tx_handshake_clear");
    rd(32'h8000_0000, 32'h1, "status_tx_free");

    // Write coinciding with handshake completion is dropped
    wr(32'h8000_0008, 32'h55);
    expect_sig(K_TXV, 32'h1, "tx55_valid");
    uart_tx_ready = 1'b1;
    we = 1'b1; addr = 32'h8000_0008; wdata = 32'h66;
    tick();
    we = 1'b0; uart_tx_ready = 1'b0;
    expect_sig(K_TXV, 32'h0, "tx_wr_at_hs_valid");
    expect_sig(K_TXD, 32'h55, "tx_wr_at_hs_data");

    // Fill FIFO with 9 offers; ninth refused
    for (int i = 1; i <= 9; i++) begin
      uart_rx_valid = 1'b1;
      uart_rx_data  = 8'(i);
      expect_sig(K_RXR, (i <= 8) ? 32'h1 : 32'h0, "rx_ready_fill");
      tick();
    end
    // Pop on full: succeeds, ready back next cycle, then 0x09 lands
    rd(32'h8000_0004, 32'h1, "rx_pop_full");
    expect_sig(K_RXR, 32'h1, "rx_ready_after_pop");
    rd(32'h8000_0004, 32'h2, "rx_pop_push");
    uart_rx_valid = 1'b0;
    for (int i = 3; i <= 9; i++) rd(32'h8000_0004, 32'(i), "rx_drain");
    rd(32'h8000_0004, 32'h0, "rx_empty_read");

    // Push and read on an empty FIFO in the same cycle
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'hC3;
    rd(32'h8000_0004, 32'h0, "rx_push_read_empty");
    uart_rx_valid = 1'b0;
    rd(32'h8000_0000, 32'h3, "status_after_push_read");
    rd(32'h8000_0004, 32'hC3, "rx_c3_retained");

    // Instruction counter and clear priority
    wr(32'h8000_0018, 32'h0);
    instr_commit = 1'b1;
    repeat (3) tick();
    instr_commit = 1'b0;
    rd(32'h8000_0014, 32'd3, "inst_cnt_3");
    instr_commit = 1'b1;
    wr(32'h8000_0018, 32'h0);
    instr_commit = 1'b0;
    rd(32'h8000_0014, 32'd0, "inst_clr_wins");

    // Cycle counter wrap
    force dut.cyc_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_cnt_q;
    rd(32'h8000_0010, 32'hFFFF_FFFF, "cyc_max");
    rd(32'h8000_0010, 32'h0, "cyc_wrap");

    // Address handling
    rd(32'h8000_0010, 32'h1, "cyc_after_wrap");
    re = 1'b1; we = 1'b1; addr = 32'h8000_0010;
    sb.push_back('{"re_we_both", K_RDATA, 32'h0, cyc_tb + 1});
    tick();
    re = 1'b0; we = 1'b0;
    rd(32'h8000_0000, 32'h1, "status_before_oow");
    rd(32'h0000_0010, 32'h0, "out_of_window");
    rd(32'h8000_0000, 32'h1, "status_before_hole");
    rd(32'h8000_000C, 32'h0, "unmapped_hole");

    // Reset mid-operation
    for (int i = 0; i < 3; i++) begin
      uart_rx_valid = 1'b1;
      uart_rx_data  = 8'(8'hA0 + i);
      tick();
    end
    uart_rx_valid = 1'b0;
    wr(32'h8000_0008, 32'h77);
    rd(32'h8000_0000, 32'h2, "status_before_rst");
    expect_sig(K_TXV, 32'h1, "txv_before_rst");
    rst = 1'b1;
    tick();
    n_cmp++;
    if (uart_tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL inline_midrst_txv: got %b expected 0", uart_tx_valid);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (uart_rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL inline_midrst_rxready: got %b expected 1", uart_rx_ready);
    end
    expect_sig(K_TXV, 32'h0, "midrst_txv");
    expect_sig(K_TXD, 32'h0, "midrst_txd");
    expect_sig(K_RDATA, 32'h0, "midrst_rdata");
    rd(32'h8000_0000, 32'h1, "midrst_status");
    rd(32'h8000_0004, 32'h0, "midrst_rx_empty");

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    while (sb.size() > 0) begin
      n_fail++;
      $display("FAIL %s: got no check expected 0x%08h", sb[0].name, sb[0].exp);
      void'(sb.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
